fd_control_unit: RTL

Multicycle control FSM that sits directly upstream of the fetch/decode datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath strobes: PC load, IR load, register/memory write enables, operand/writeback select, add/sub and branch-flag select. Its only inputs are the opcode fields of the instruction register and a run request.

---
 rtl/fd_control_unit_if.sv | 38 +++
 rtl/fd_control_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fd_control_unit_if.sv
// fd_control_unit_if
//   Bundles the control unit's instruction-field/run inputs with the datapath
//   strobes and status it produces.
//   master : control unit side (consumes run/opcode fields, drives strobes)
//   slave  : datapath side (drives run/opcode fields, consumes strobes)
//   Signals: run, opcode[6:0], funct3[2:0], funct7_5, PC_load, IR_load,
//            WE_reg, WE_mem, OP_MEM_I[1:0], ADD_SUB, select_flags[2:0],
//            halted, busy, retired[COUNT_W-1:0]
interface fd_control_unit_if #(
  parameter int COUNT_W = 16
);
  logic               run;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               funct7_5;
  logic               PC_load;
  logic               IR_load;
  logic               WE_reg;
  logic               WE_mem;
  logic [1:0]         OP_MEM_I;
  logic               ADD_SUB;
  logic [2:0]         select_flags;
  logic               halted;
  logic               busy;
  logic [COUNT_W-1:0] retired;

  modport master (
    input  run, opcode, funct3, funct7_5,
    output PC_load, IR_load, WE_reg, WE_mem, OP_MEM_I, ADD_SUB,
           select_flags, halted, busy, retired
  );

  modport slave (
    output run, opcode, funct3, funct7_5,
    input  PC_load, IR_load, WE_reg, WE_mem, OP_MEM_I, ADD_SUB,
           select_flags, halted, busy, retired
  );
endinterface

// File: rtl/fd_control_unit.sv
// fd_control_unit
//   Multicycle control FSM sequencing each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and driving the datapath strobes.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-low
//     bus   : fd_control_unit_if.master (run + IR fields in, strobes/status out)
//   All outputs decode from the registered state and the fields latched in
//   DECODE, so nothing on the input side reaches an output combinationally.
module fd_control_unit #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  fd_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BR
  } cls_t;

  state_t             state_q, next_state, end_state;
  cls_t               cls_q, dec_cls;
  logic [1:0]         opmem_q, dec_opmem;
  logic               addsub_q, dec_addsub;
  logic [2:0]         sel_q, dec_sel;
  logic               dec_legal;
  logic [COUNT_W-1:0] retired_q;

  logic               pc_load, ir_load, we_reg, we_mem, add_sub;
  logic [1:0]         op_mem_i;
  logic [2:0]         select_flags;

  // Instruction classification; only consumed while in DECODE.
  always_comb begin
    dec_legal  = 1'b1;
    dec_cls    = CLS_R;
    dec_opmem  = 2'b00;
    dec_addsub = 1'b0;
    dec_sel    = 3'd7;
    case (bus.opcode)
      7'b0110011: begin
        dec_cls    = CLS_R;
        dec_addsub = bus.funct7_5;
        dec_legal  = (bus.funct3 == 3'b000);
      end
      7'b0010011: begin
        dec_cls   = CLS_ADDI;
        dec_opmem = 2'b01;
        dec_legal = (bus.funct3 == 3'b000);
      end
      7'b0000011: begin
        dec_cls   = CLS_LW;
        dec_opmem = 2'b11;
        dec_legal = (bus.funct3 == 3'b010);
      end
      7'b0100011: begin
        dec_cls   = CLS_SW;
        dec_opmem = 2'b01;
        dec_legal = (bus.funct3 == 3'b010);
      end
      7'b1100011: begin
        dec_cls    = CLS_BR;
        dec_addsub = 1'b1;
        // funct3 -> flag-mux index (eq, ne, lt, ge, ltu, geu)
        case (bus.funct3)
          3'b000:  dec_sel = 3'd0;
          3'b001:  dec_sel = 3'd1;
          3'b100:  dec_sel = 3'd2;
          3'b101:  dec_sel = 3'd3;
          3'b110:  dec_sel = 3'd4;
          3'b111:  dec_sel = 3'd5;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Controls captured at the end of DECODE are held until the instruction ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_q    <= CLS_R;
      opmem_q  <= 2'b00;
      addsub_q <= 1'b0;
      sel_q    <= 3'd7;
    end else if (state_q == ST_DECODE && dec_legal) begin
      cls_q    <= dec_cls;
      opmem_q  <= dec_opmem;
      addsub_q <= dec_addsub;
      sel_q    <= dec_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (pc_load) begin
      retired_q <= retired_q + COUNT_W'(1);
    end
  end

  // Next-state and strobe decode. run is only looked at in IDLE and on the
  // last cycle of an instruction, so dropping it mid-instruction is harmless.
  always_comb begin
    next_state   = state_q;
    end_state    = bus.run ? ST_FETCH : ST_IDLE;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    we_reg       = 1'b0;
    we_mem       = 1'b0;
    op_mem_i     = 2'b00;
    add_sub      = 1'b0;
    select_flags = 3'd7;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        ir_load    = 1'b1;
        next_state = ST_DECODE;
      end
      ST_DECODE: begin
        next_state = dec_legal ? ST_EXEC : ST_HALT;
      end
      ST_EXEC: begin
        op_mem_i = opmem_q;
        add_sub  = addsub_q;
        case (cls_q)
          CLS_BR: begin
            pc_load      = 1'b1;
            select_flags = sel_q;
            next_state   = end_state;
          end
          CLS_LW, CLS_SW: next_state = ST_MEM;
          default:        next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        op_mem_i = opmem_q;
        add_sub  = addsub_q;
        if (cls_q == CLS_SW) begin
          we_mem     = 1'b1;
          pc_load    = 1'b1;
          next_state = end_state;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_WB: begin
        op_mem_i   = opmem_q;
        add_sub    = addsub_q;
        we_reg     = 1'b1;
        pc_load    = 1'b1;
        next_state = end_state;
      end
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IDLE;
    endcase
  end

  assign bus.PC_load      = pc_load;
  assign bus.IR_load      = ir_load;
  assign bus.WE_reg       = we_reg;
  assign bus.WE_mem       = we_mem;
  assign bus.OP_MEM_I     = op_mem_i;
  assign bus.ADD_SUB      = add_sub;
  assign bus.select_flags = select_flags;
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign bus.retired      = retired_q;

endmodule
